// File: rtl/fpga_robots_game_alert.sv
// fpga_robots_game_alert
// Multi-source attention / beep generator. NCH alert sources post one-cycle
// request pulses; each source has its own length in video frames and its own
// tone half-period in tick counts. The highest-index pending source plays.
// A higher source preempts the one playing, and the preempted source is dropped.
// A repeat request from the playing source restarts its frame count.
// Lower sources wait their turn. An optional run of silent frames separates
// consecutive alerts.
//
// Request interface: req[i] is a fire-and-forget pulse with no ready/ack.
// Each pulse sets a sticky pending bit, so a pulse is never lost. Several
// pulses on one channel before it is serviced merge into one request.
// req_dur and tone_div are sampled only in the cycle a channel is loaded.
module fpga_robots_game_alert #(
   parameter int NCH  = 4,
   parameter int DURW = 5,
   parameter int DIVW = 8,
   parameter int GAPF = 4,
   parameter int MODE = 0,
   localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int GW  = (GAPF > 0) ? $clog2(GAPF + 1) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame,
   input  logic                 tick,
   input  logic [NCH-1:0]       req,
   input  logic [NCH*DURW-1:0]  req_dur,
   input  logic [NCH*DIVW-1:0]  tone_div,
   output logic                 attention,
   output logic                 audio,
   output logic                 busy,
   output logic [AW-1:0]        active_ch
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [NCH-1:0]  pend, pend_n;
   logic [DURW-1:0] ctr, ctr_n;
   logic [GW-1:0]   gctr, gctr_n;
   logic [DIVW-1:0] divc, divc_n;
   logic [DIVW-1:0] tone, tone_n;
   logic [AW-1:0]   cur, cur_n;
   logic            audio_r, audio_n;

   // Arbitration results and the fields of the candidate channels.
   logic            top_any, hi_any;
   logic [AW-1:0]   top_idx, hi_idx;
   logic [DURW-1:0] top_dur, hi_dur, cur_dur;
   logic [DIVW-1:0] top_tone, hi_tone;
   logic            reload;
   logic            show;

   // Priority encoders: the highest pending channel overall, and the highest pending channel above cur.
   always_comb begin
      top_any = 1'b0;
      top_idx = '0;
      hi_any  = 1'b0;
      hi_idx  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (pend[i]) begin
            top_any = 1'b1;
            top_idx = AW'(i);
         end
         if (pend[i] && (i > int'(cur))) begin
            hi_any = 1'b1;
            hi_idx = AW'(i);
         end
      end
   end

   // Fetch duration/tone fields for the channels the control logic may load.
   always_comb begin
      top_dur  = '0;
      top_tone = '0;
      hi_dur   = '0;
      hi_tone  = '0;
      cur_dur  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (top_idx == AW'(i)) begin
            top_dur  = req_dur[i*DURW +: DURW];
            top_tone = tone_div[i*DIVW +: DIVW];
         end
         if (hi_idx == AW'(i)) begin
            hi_dur  = req_dur[i*DURW +: DURW];
            hi_tone = tone_div[i*DIVW +: DIVW];
         end
         if (cur == AW'(i)) begin
            cur_dur = req_dur[i*DURW +: DURW];
         end
      end
   end

   // Next-state logic: start, preempt, retrigger, frame counting, gap and tone divider.
   always_comb begin
      state_n = state;
      pend_n  = pend | req;
      ctr_n   = ctr;
      gctr_n  = gctr;
      divc_n  = divc;
      tone_n  = tone;
      cur_n   = cur;
      audio_n = audio_r;
      reload  = 1'b0;

      case (state)
         IDLE: begin
            if (top_any) begin
               // The started channel's bit is cleared even if a new pulse lands this cycle.
               pend_n[top_idx] = 1'b0;
               // A zero-length request is consumed silently.
               if (top_dur != '0) begin
                  cur_n   = top_idx;
                  ctr_n   = top_dur;
                  tone_n  = top_tone;
                  divc_n  = top_tone;
                  audio_n = 1'b0;
                  state_n = PLAY;
               end
            end
         end

         PLAY: begin
            // Tone divider: toggle when the half-period count expires.
            if (tick) begin
               if (divc == '0) begin
                  audio_n = ~audio_r;
                  divc_n  = tone;
               end else begin
                  divc_n = divc - DIVW'(1);
               end
            end

            if (hi_any) begin
               // Preemption: a higher channel takes over with a fresh tone phase.
               // A zero-length preemptor is discarded and leaves the current alert alone.
               pend_n[hi_idx] = 1'b0;
               if (hi_dur != '0) begin
                  cur_n   = hi_idx;
                  ctr_n   = hi_dur;
                  tone_n  = hi_tone;
                  divc_n  = hi_tone;
                  audio_n = 1'b0;
                  reload  = 1'b1;
               end
            end else if (pend[cur]) begin
               // Retrigger: restart the frame count, keep the tone phase running.
               pend_n[cur] = 1'b0;
               if (cur_dur != '0) begin
                  ctr_n  = cur_dur;
                  reload = 1'b1;
               end
            end

            // A reload in the same cycle as a frame pulse takes precedence.
            if (!reload && frame) begin
               if (ctr == DURW'(1)) begin
                  audio_n = 1'b0;
                  gctr_n  = GW'(GAPF);
                  state_n = (GAPF == 0) ? IDLE : GAP;
               end else if (ctr > DURW'(1)) begin
                  ctr_n = ctr - DURW'(1);
               end
            end
         end

         GAP: begin
            // Silent frames; requests keep accumulating in pend.
            audio_n = 1'b0;
            if (frame) begin
               if (gctr == GW'(1)) begin
                  state_n = IDLE;
               end
               if (gctr != '0) begin
                  gctr_n = gctr - GW'(1);
               end
            end
         end

         default: begin
            state_n = IDLE;
            audio_n = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pend    <= '0;
         ctr     <= '0;
         gctr    <= '0;
         divc    <= '0;
         tone    <= '0;
         cur     <= '0;
         audio_r <= 1'b0;
      end else begin
         state   <= state_n;
         pend    <= pend_n;
         ctr     <= ctr_n;
         gctr    <= gctr_n;
         divc    <= divc_n;
         tone    <= tone_n;
         cur     <= cur_n;
         audio_r <= audio_n;
      end
   end

   // In pulsed mode the alert shows only on frames where the remaining count is odd.
   assign show      = (state == PLAY) && ((MODE == 0) || ctr[0]);
   assign attention = show;
   assign audio     = audio_r & show;
   assign busy      = (state != IDLE);
   assign active_ch = cur;

endmodule
